// File: rtl/spram_req_arbiter_if.sv
// rtl/spram_req_arbiter_if.sv - request, response and RAM-port signals of the single-port RAM front-end
interface spram_req_arbiter_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [AWIDTH-1:0] rd_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_data;

    logic              ram_wr_en;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_wr_data;
    logic [DWIDTH-1:0] ram_rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        output rsp_ready,
        output ram_rd_data,
        input  wr_ready, rd_ready,
        input  rsp_valid, rsp_data,
        input  ram_wr_en, ram_addr, ram_wr_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        input  rsp_ready,
        input  ram_rd_data,
        output wr_ready, rd_ready,
        output rsp_valid, rsp_data,
        output ram_wr_en, ram_addr, ram_wr_data
    );
endinterface

// File: rtl/spram_req_arbiter.sv
// rtl/spram_req_arbiter.sv - write/read arbiter onto a single-port RAM with a 2-entry response buffer
module spram_req_arbiter #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spram_req_arbiter_if.slave bus
);
    logic              pri;
    logic              cap;
    logic              head_valid;
    logic              spare_valid;
    logic [DWIDTH-1:0] head_data;
    logic [DWIDTH-1:0] spare_data;

    logic              head_valid_n;
    logic              spare_valid_n;
    logic [DWIDTH-1:0] head_data_n;
    logic [DWIDTH-1:0] spare_data_n;

    logic [1:0]        count;
    logic [2:0]        inflight;
    logic              pop;
    logic              push;
    logic              rd_ok;
    logic              gr;
    logic              gw;
    logic              contended;
    logic [AWIDTH-1:0] addr_mux;
    logic [DWIDTH-1:0] wdata_mux;

    assign count    = {1'b0, head_valid} + {1'b0, spare_valid};
    assign pop      = head_valid & bus.rsp_ready;
    assign push     = cap;

    // Responses already buffered plus the one being captured, less the one leaving now.
    assign inflight = {1'b0, count} + {2'b00, cap} - {2'b00, pop};
    assign rd_ok    = inflight < 3'd2;

    // cap blocks writes so the RAM read register is never cleared before it is captured.
    assign gr        = rst_n & bus.rd_valid & rd_ok & (~bus.wr_valid | cap | ~pri);
    assign gw        = rst_n & bus.wr_valid & ~cap & ~gr;
    assign contended = bus.rd_valid & rd_ok & bus.wr_valid & ~cap;

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (gw) begin
            addr_mux  = bus.wr_addr;
            wdata_mux = bus.wr_data;
        end else if (gr) begin
            addr_mux  = bus.rd_addr;
        end
    end

    assign bus.wr_ready    = gw;
    assign bus.rd_ready    = gr;
    assign bus.ram_wr_en   = gw;
    assign bus.ram_addr    = addr_mux;
    assign bus.ram_wr_data = wdata_mux;
    assign bus.rsp_valid   = head_valid;
    assign bus.rsp_data    = head_data;

    // head is the presented entry; spare holds the younger one when both are full.
    always_comb begin
        head_valid_n  = head_valid;
        head_data_n   = head_data;
        spare_valid_n = spare_valid;
        spare_data_n  = spare_data;
        case ({push, pop})
            2'b11: begin
                if (spare_valid) begin
                    head_data_n  = spare_data;
                    spare_data_n = bus.ram_rd_data;
                end else begin
                    head_data_n  = bus.ram_rd_data;
                end
            end
            2'b01: begin
                if (spare_valid) begin
                    head_data_n   = spare_data;
                    spare_valid_n = 1'b0;
                end else begin
                    head_valid_n  = 1'b0;
                end
            end
            2'b10: begin
                if (!head_valid) begin
                    head_valid_n  = 1'b1;
                    head_data_n   = bus.ram_rd_data;
                end else begin
                    spare_valid_n = 1'b1;
                    spare_data_n  = bus.ram_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri         <= 1'b0;
            cap         <= 1'b0;
            head_valid  <= 1'b0;
            head_data   <= '0;
            spare_valid <= 1'b0;
            spare_data  <= '0;
        end else begin
            cap         <= gr;
            if (contended) begin
                pri <= ~pri;
            end
            head_valid  <= head_valid_n;
            head_data   <= head_data_n;
            spare_valid <= spare_valid_n;
            spare_data  <= spare_data_n;
        end
    end
endmodule
